// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one synchronous memory port between IF and DM
module mem_port_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY);

    // Grant encoding: 0 = instruction fetch, 1 = data port.
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic               grant;
    logic               last_grant;
    logic               mask_pend;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  dm_rdata_q;

    logic               if_vld;
    logic               dm_vld;
    logic               pick_dm;
    logic               wait_done;

    // Request qualification, round-robin choice and next-state decode.
    always_comb begin
        next_state = state;
        if_vld     = if_req & ~(mask_pend & (last_grant == GNT_IF));
        dm_vld     = dm_req & ~(mask_pend & (last_grant == GNT_DM));
        pick_dm    = dm_vld & (~if_vld | (last_grant == GNT_IF));
        wait_done  = (count == LAT_LAST);
        case (state)
            IDLE:    if (if_vld | dm_vld) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant latches, latency counter, read-data capture and fairness history.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            grant      <= GNT_IF;
            last_grant <= GNT_DM;
            mask_pend  <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            // Only the single IDLE cycle right after RESP masks the served requester.
            mask_pend <= (state == RESP);
            case (state)
                IDLE: begin
                    if (if_vld | dm_vld) begin
                        grant     <= pick_dm;
                        lat_we    <= pick_dm ? dm_we : 1'b0;
                        lat_addr  <= pick_dm ? dm_addr : if_addr;
                        lat_wdata <= pick_dm ? dm_wdata : '0;
                    end
                end
                ISSUE: begin
                    count <= CNT_W'(1);
                end
                WAIT: begin
                    if (wait_done) begin
                        if (!lat_we) begin
                            if (grant == GNT_DM) begin
                                dm_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode purely from registered state; no req input reaches them combinationally.
    always_comb begin
        mem_en    = (state == ISSUE);
        mem_we    = (state == ISSUE) & lat_we;
        mem_addr  = (state == ISSUE) ? lat_addr : '0;
        mem_wdata = (state == ISSUE) ? lat_wdata : '0;
        if_ack    = (state == RESP) & (grant == GNT_IF);
        dm_ack    = (state == RESP) & (grant == GNT_DM);
        busy      = (state != IDLE);
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
    end

endmodule
